seq_state_gen: RTL and testbench

//  Parametrised autonomous state-sequence generator: WIDTH-bit state register stepped per selectable mode
//  (hold / binary count / Johnson / XNOR-LFSR), with output y = OR-reduction of masked state bits.

---
 rtl/seq_state_gen.sv | 115 +++++++++++
 tb/tb_seq_state_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_state_gen.sv
// seq_state_gen: autonomous WIDTH-bit sequence generator with selectable
// stepping rule (hold / binary count / Johnson / XNOR-LFSR), parallel load,
// anchor-to-anchor period measurement and LFSR lock-up recovery.
module seq_state_gen #(
    parameter int              WIDTH  = 3,
    parameter logic [WIDTH-1:0] TAPS   = 3'b110,
    parameter logic [WIDTH-1:0] Y_MASK = 3'b011,
    parameter int              PER_W  = WIDTH + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state,
    output logic             y,
    output logic             wrap,
    output logic             lockup,
    output logic [PER_W-1:0] period,
    output logic             period_vld
);

    typedef enum logic [1:0] {
        MODE_HOLD    = 2'b00,
        MODE_COUNT   = 2'b01,
        MODE_JOHNSON = 2'b10,
        MODE_LFSR    = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] ALL_ONES   = {WIDTH{1'b1}};
    localparam logic [PER_W-1:0] STEPS_MAX  = {PER_W{1'b1}};

    // anchor is the value the current measurement started from; a step that
    // lands back on it closes one period.
    logic [WIDTH-1:0] anchor;
    logic [PER_W-1:0] steps;

    mode_e            mode_q;
    logic [WIDTH-1:0] step_next;
    logic             lock_hit;
    logic             counted;
    logic             anchor_hit;
    logic [PER_W-1:0] steps_inc;

    // Candidate successor of the current state under the selected mode.
    always_comb begin
        mode_q    = mode_e'(mode);
        step_next = state;
        lock_hit  = 1'b0;
        unique case (mode_q)
            MODE_HOLD:    step_next = state;
            MODE_COUNT:   step_next = state + 1'b1;
            MODE_JOHNSON: step_next = {state[WIDTH-2:0], ~state[WIDTH-1]};
            MODE_LFSR: begin
                // XNOR feedback sticks at all-ones; force the exit to zero.
                if (state == ALL_ONES) begin
                    step_next = '0;
                    lock_hit  = 1'b1;
                end else begin
                    step_next = {state[WIDTH-2:0], ~^(state & TAPS)};
                end
            end
            default:      step_next = state;
        endcase
    end

    // Qualify the step and derive the period bookkeeping for it.
    always_comb begin
        counted    = en && !load && (mode_q != MODE_HOLD);
        anchor_hit = counted && (step_next == anchor);
        steps_inc  = (steps == STEPS_MAX) ? steps : steps + 1'b1;
    end

    // State, anchor, step counter, period and event pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= '0;
            anchor     <= '0;
            steps      <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            wrap       <= 1'b0;
            lockup     <= 1'b0;
        end else if (load) begin
            state      <= load_val;
            anchor     <= load_val;
            steps      <= '0;
            period_vld <= 1'b0;
            wrap       <= 1'b0;
            lockup     <= 1'b0;
        end else if (counted) begin
            state  <= step_next;
            lockup <= lock_hit;
            if (anchor_hit) begin
                wrap       <= 1'b1;
                period     <= steps + 1'b1;
                period_vld <= 1'b1;
                steps      <= '0;
            end else begin
                wrap  <= 1'b0;
                steps <= steps_inc;
            end
        end else begin
            wrap   <= 1'b0;
            lockup <= 1'b0;
        end
    end

    // Activity output straight from the registered state.
    always_comb begin
        y = |(state & Y_MASK);
    end

endmodule

// File: tb/tb_seq_state_gen.sv
// Bench for seq_state_gen: directed scenarios followed by random traffic,
// every cycle compared against an arithmetic reference model.
module tb_seq_state_gen;

    localparam int W     = 3;
    localparam int SMASK = (1 << W) - 1;
    localparam int PMASK = (1 << (W + 1)) - 1;
    localparam int TAPSV = 6;
    localparam int YMSKV = 3;

    logic         clk = 1'b0;
    logic         reset, en, load;
    logic [1:0]   mode;
    logic [W-1:0] load_val;
    logic [W-1:0] state;
    logic         y, wrap, lockup, period_vld;
    logic [W:0]   period;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_state, m_anchor, m_steps, m_period;
    bit m_pvld, m_wrap, m_lock;

    seq_state_gen #(
        .WIDTH(W), .TAPS(3'b110), .Y_MASK(3'b011), .PER_W(W + 1)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load),
        .load_val(load_val), .state(state), .y(y), .wrap(wrap),
        .lockup(lockup), .period(period), .period_vld(period_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // successor of s by the rule for mode md; lk reports an all-ones LFSR exit
    function automatic int succ(input int s, input int md, output bit lk);
        lk = 1'b0;
        case (md)
            1: return (s + 1) % (SMASK + 1);
            2: return ((s * 2) & SMASK) | (((s >> (W - 1)) & 1) ^ 1);
            3: begin
                if (s == SMASK) begin
                    lk = 1'b1;
                    return 0;
                end
                return ((s * 2) & SMASK) | ((($countones(s & TAPSV)) % 2) ^ 1);
            end
            default: return s;
        endcase
    endfunction

    task automatic model_edge(input bit r, input bit l, input bit e, input int md, input int lv);
        int n;
        bit lk;
        if (r) begin
            m_state = 0; m_anchor = 0; m_steps = 0; m_period = 0;
            m_pvld = 0; m_wrap = 0; m_lock = 0;
        end else if (l) begin
            m_state = lv; m_anchor = lv; m_steps = 0; m_pvld = 0;
            m_wrap = 0; m_lock = 0;
        end else if (e && md != 0) begin
            n = succ(m_state, md, lk);
            m_lock = lk;
            if (n == m_anchor) begin
                m_wrap = 1; m_period = (m_steps + 1) & PMASK; m_pvld = 1; m_steps = 0;
            end else begin
                m_wrap = 0;
                if (m_steps < PMASK) m_steps++;
            end
            m_state = n;
        end else begin
            m_wrap = 0; m_lock = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},  state,      m_state);
        chk({tag, ".y"},      y,          ((m_state & YMSKV) != 0));
        chk({tag, ".wrap"},   wrap,       m_wrap);
        chk({tag, ".lockup"}, lockup,     m_lock);
        chk({tag, ".period"}, period,     m_period);
        chk({tag, ".pvld"},   period_vld, m_pvld);
    endtask

    // one clock: drive inputs, advance model at the edge, check 1 time unit later
    task automatic cyc(input bit r, input bit l, input bit e, input int md, input int lv,
                       input string tag);
        reset = r; load = l; en = e; mode = md[1:0]; load_val = lv[W-1:0];
        @(posedge clk);
        model_edge(r, l, e, md, lv);
        #1;
        check_all(tag);
    endtask

    initial begin
        int lfsr_exp[7];
        int lfsr_y[7];
        int gap;
        bit seen;
        lfsr_exp = '{1, 3, 6, 5, 2, 4, 0};
        lfsr_y   = '{1, 1, 1, 1, 1, 0, 0};
        reset = 1'b1; en = 1'b0; load = 1'b0; mode = 2'b00; load_val = '0;
        m_state = 0; m_anchor = 0; m_steps = 0; m_period = 0;
        m_pvld = 0; m_wrap = 0; m_lock = 0;

        // reset, then idle
        cyc(1, 0, 0, 0, 0, "rst0");
        cyc(1, 0, 0, 0, 0, "rst1");
        cyc(0, 0, 0, 0, 0, "idle");
        chk("rst.state", state, 0);
        chk("rst.y", y, 0);
        chk("rst.pvld", period_vld, 0);

        // LFSR full cycle from zero
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 1, 3, 0, "lfsr");
            chk("lfsr.seq", state, lfsr_exp[i]);
            chk("lfsr.yseq", y, lfsr_y[i]);
            chk("lfsr.wrapseq", wrap, (i == 6));
        end
        chk("lfsr.period", period, 7);
        chk("lfsr.pvld", period_vld, 1);

        // Johnson cycle, then binary count cycle
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 2, 0, "john");
        chk("john.wrap", wrap, 1);
        chk("john.period", period, 6);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 1, 0, "cnt");
        chk("cnt.wrap", wrap, 1);
        chk("cnt.period", period, 8);

        // lock-up recovery; anchor 111 unreachable so steps saturate
        cyc(0, 1, 0, 3, 7, "ld111");
        cyc(0, 0, 1, 3, 0, "lock");
        chk("lock.pulse", lockup, 1);
        chk("lock.state", state, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 3, 0, "sat");
        chk("sat.pvld", period_vld, 0);
        // counting up to 111 closes a period of 16 steps, which folds to 0
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            cyc(0, 0, 1, 1, 0, "satcnt");
            seen = wrap;
        end
        chk("sat.wrapseen", seen, 1);
        chk("sat.period", period, 0);
        chk("sat.pvld2", period_vld, 1);

        // load wins over en; en gaps leave period intact
        cyc(0, 1, 1, 1, 5, "ld_en");
        chk("ld_en.state", state, 5);
        chk("ld_en.pvld", period_vld, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 1, 0, "gap");
            cyc(0, 0, 1, 1, 0, "gapstep");
        end
        chk("gap.period", period, 8);
        chk("gap.wrap", wrap, 1);

        // reset mid-run at state 110
        cyc(0, 1, 0, 3, 0, "ld0");
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 3, 0, "pre");
        chk("pre.state", state, 6);
        cyc(1, 0, 1, 3, 0, "midrst");
        chk("midrst.state", state, 0);
        chk("midrst.period", period, 0);
        chk("midrst.pvld", period_vld, 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            gap = $urandom_range(0, 99);
            cyc(gap < 2, gap >= 2 && gap < 8, $urandom_range(0, 3) != 0,
                $urandom_range(0, 3), $urandom_range(0, SMASK), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
